conv_ofmap_collector: RTL and testbench

- Receive side of the conv_control result interface. Captures the fp16 result words that conv_control emits on dout_valid into a 2x2 ofmap buffer.
- Holds one complete output frame, then drains it to the downstream consumer, such as the writeback to the E203 ICB/SRAM path, over a valid/ready stream.
- Detects protocol violations from the controller side: short frames and overruns.

---
 rtl/conv_ofmap_collector.sv | 97 +++++++++
 tb/tb_conv_ofmap_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ofmap_collector.sv
// conv_ofmap_collector: captures one conv_control result frame and drains it over a valid/ready stream
module conv_ofmap_collector #(
  parameter int DATA_W  = 16,
  parameter int OFMAP_N = 4,
  parameter int CNT_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        conv_done,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [OFMAP_N*DATA_W-1:0]   ofmap_flat,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic                        frame_done,
  output logic                        err_short,
  output logic                        err_overrun,
  input  logic                        err_clr
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  localparam logic [CNT_W-1:0] full_cnt = CNT_W'(OFMAP_N);
  localparam logic [CNT_W-1:0] one_cnt  = CNT_W'(1);
  state_t           state;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, wr_idx, wr_nx, rd_nx;
  logic             take_start, wr_en, accept;
  assign take_start = state == IDLE && start && !frame_done;
  assign wr_en      = din_valid && (take_start || state == COLLECT);
  assign wr_idx     = state == IDLE ? '0 : wr_cnt;
  assign wr_nx      = wr_idx + CNT_W'(wr_en);
  assign rd_nx      = rd_cnt + one_cnt;
  assign accept     = m_valid && m_ready;
  assign frame_cnt  = wr_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      ofmap_flat  <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (err_clr) begin
        err_short   <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (wr_en) ofmap_flat[wr_idx*DATA_W +: DATA_W] <= din;
      case (state)
        IDLE: begin
          if (take_start) begin
            state  <= COLLECT;
            wr_cnt <= wr_nx;
          end else if (din_valid) begin
            err_overrun <= 1'b1;
          end
        end
        COLLECT: begin
          wr_cnt <= wr_nx;
          if (wr_nx == full_cnt || (conv_done && wr_nx != '0)) begin
            state   <= DRAIN;
            rd_cnt  <= '0;
            m_valid <= 1'b1;
            m_data  <= (wr_en && wr_idx == '0) ? din : ofmap_flat[DATA_W-1:0];
            m_last  <= wr_nx == one_cnt;
          end else if (conv_done) begin
            state <= IDLE;
          end
          if (conv_done && wr_nx != full_cnt) err_short <= 1'b1;
        end
        DRAIN: begin
          if (din_valid) err_overrun <= 1'b1;
          if (accept && m_last) begin
            state      <= IDLE;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            frame_done <= 1'b1;
          end else if (accept) begin
            rd_cnt <= rd_nx;
            m_data <= ofmap_flat[rd_nx*DATA_W +: DATA_W];
            m_last <= rd_nx == wr_cnt - one_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_ofmap_collector.sv
// tb_conv_ofmap_collector: scoreboard bench with a frame-level reference model
module tb_conv_ofmap_collector;
  logic clk = 1'b0;
  logic rst, start, din_valid, conv_done, err_clr;
  logic m_ready = 1'b0;
  logic [15:0] din;
  logic [15:0] m_data;
  logic m_valid, m_last, frame_done, err_short, err_overrun;
  logic [63:0] ofmap_flat;
  logic [2:0] frame_cnt;
  int n_checks = 0, n_pass = 0, rmode = 0, cyc = 0;
  logic [16:0] sb[$];
  logic [15:0] w[4];
  logic [63:0] exp_flat = '0;
  logic exp_short = 1'b0, exp_over = 1'b0;
  logic prev_valid = 1'b0, prev_acc = 1'b0, prev_last = 1'b0, fd_exp = 1'b0;
  logic [15:0] prev_data = '0;

  conv_ofmap_collector dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .conv_done(conv_done), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .ofmap_flat(ofmap_flat), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .err_short(err_short), .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc % 4 == 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_acc = 1'b0;
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      if (prev_valid && !prev_acc) chk("hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %h expected none", m_data);
        end else chk("beat", {m_last, m_data}, sb.pop_front());
      end
      fd_exp = m_valid && m_ready && m_last;
      prev_valid = m_valid;
      prev_acc = m_valid && m_ready;
      prev_last = m_last;
      prev_data = m_data;
    end
  end

  task automatic chk_zero();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_flat", ofmap_flat, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_short, err_overrun}, 0);
  endtask

  task automatic clr_err();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_short = 1'b0;
    exp_over = 1'b0;
    @(negedge clk);
    chk("err_clr", {err_short, err_overrun}, 0);
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() > 0 && i < 2000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input bit sw, input bit dol, input bit rnd, input bit ovr, input bit b2b);
    int idx = 0;
    for (int k = 0; k < n; k++) begin
      sb.push_back({1'(k == n - 1), w[k]});
      exp_flat[k*16 +: 16] = w[k];
    end
    if (n < 4) exp_short = 1'b1;
    step();
    start = 1'b1;
    if (sw) begin
      din_valid = 1'b1;
      din = w[0];
      idx = 1;
    end
    step();
    start = 1'b0;
    din_valid = 1'b0;
    while (idx < n) begin
      if (rnd && $urandom_range(0, 2) == 0) step();
      din_valid = 1'b1;
      din = w[idx];
      conv_done = dol && idx == n - 1;
      idx++;
      step();
      din_valid = 1'b0;
      conv_done = 1'b0;
    end
    if (n < 4 && !dol) begin
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
    end
    @(negedge clk);
    chk("frame_cnt", frame_cnt, 64'(n));
    chk("flat", ofmap_flat, exp_flat);
    chk("err_short", err_short, exp_short);
    chk("err_overrun", err_overrun, exp_over);
    if (ovr) begin
      step();
      din_valid = 1'b1;
      din = 16'h7BFF;
      step();
      err_clr = 1'b1;
      step();
      din_valid = 1'b0;
      err_clr = 1'b0;
      exp_over = 1'b1;
      exp_short = 1'b0;
      @(negedge clk);
      chk("ovr_set_wins", err_overrun, 1);
      chk("ovr_flat", ofmap_flat, exp_flat);
    end
    if (n > 0) wait_drain();
    if (b2b) begin
      start = 1'b1;
      step();
      start = 1'b0;
      din_valid = 1'b1;
      din = 16'($urandom);
      step();
      din_valid = 1'b0;
      exp_over = 1'b1;
      @(negedge clk);
      chk("b2b_frame_cnt", frame_cnt, 0);
      chk("b2b_overrun", err_overrun, 1);
    end
    step();
    @(negedge clk);
    chk("idle_frame_cnt", frame_cnt, 0);
    chk("idle_flat", ofmap_flat, exp_flat);
    chk("idle_m_valid", m_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; conv_done = 1'b0; err_clr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero();
    w = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    run_frame(4, 0, 0, 0, 0, 0);
    chk("t1_flat", ofmap_flat, 64'h4400_4200_4000_3C00);
    rmode = 2;
    run_frame(4, 0, 0, 0, 0, 0);
    rmode = 0;
    w[0] = 16'h3800;
    w[1] = 16'hBC00;
    run_frame(2, 0, 0, 0, 0, 0);
    chk("t3_err_short", err_short, 1);
    clr_err();
    rmode = 2;
    for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
    run_frame(4, 0, 0, 0, 1, 0);
    clr_err();
    rmode = 0;
    w = '{16'h4500, 16'h4600, 16'h4700, 16'h4800};
    run_frame(4, 1, 1, 0, 0, 0);
    chk("t5_err_short", err_short, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din_valid = 1'b1;
      din = 16'h1111 * 16'(k + 1);
      step();
    end
    din_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_flat = '0;
    exp_short = 1'b0;
    exp_over = 1'b0;
    chk_zero();
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_frame(4, 0, 0, 0, 0, 1);
    clr_err();
    rmode = 1;
    for (int it = 0; it < 25; it++) begin
      int n = $urandom_range(0, 4);
      for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        step();
        din_valid = 1'b1;
        din = 16'($urandom);
        step();
        din_valid = 1'b0;
        exp_over = 1'b1;
      end
      run_frame(n, n > 0 && $urandom_range(0, 1) == 1, n == 4 && $urandom_range(0, 1) == 1, 1, 0, 0);
      clr_err();
    end
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
